// File: rtl/bus_dma.sv
// Word-by-word memory copy bus initiator: reads one 32-bit word, writes it,
// and repeats until the count is exhausted or a bus phase times out.
module bus_dma #(
   parameter int LEN_WIDTH = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          src_address,
   input  logic [31:0]          dst_address,
   input  logic [LEN_WIDTH-1:0] length,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 read,
   output logic                 write,
   output logic [31:0]          address,
   output logic [31:0]          write_data,
   input  logic [31:0]          read_data,
   input  logic                 response,
   output logic [1:0]           dbg_state
);

   // Bus handshake: read/write is held with a stable address (and write_data)
   // until response is high in the same cycle; response is ignored otherwise.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD     = 2'd1,
      WR     = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [31:0]          src_q, src_d;
   logic [31:0]          dst_q, dst_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          buf_q, buf_d;
   logic [15:0]          wait_q, wait_d;
   logic                 error_q, error_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         wait_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         wait_q  <= wait_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      wait_d     = wait_q;
      error_d    = error_q;
      busy       = 1'b0;
      done       = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      write_data = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               error_d = 1'b0;
               if (length != '0) begin
                  src_d   = src_address;
                  dst_d   = dst_address;
                  cnt_d   = length;
                  wait_d  = '0;
                  state_d = RD;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         RD: begin
            busy    = 1'b1;
            read    = 1'b1;
            address = src_q;
            if (response) begin
               buf_d   = read_data;
               src_d   = src_q + 32'd4;
               wait_d  = '0;
               state_d = WR;
            end else if (wait_q == WAIT_LIMIT) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         WR: begin
            busy       = 1'b1;
            write      = 1'b1;
            address    = dst_q;
            write_data = buf_q;
            if (response) begin
               dst_d   = dst_q + 32'd4;
               cnt_d   = cnt_q - 1'b1;
               wait_d  = '0;
               // Compare the pre-decrement count so the last word exits here.
               state_d = (cnt_q == LEN_WIDTH'(1)) ? FINISH : RD;
            end else if (wait_q == WAIT_LIMIT) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign error     = error_q;
   assign dbg_state = state_q;

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter LEN_WIDTH, default 16, width of the word-count input.
REQ-002 Parameter TIMEOUT, default 255, maximum consecutive cycles a bus phase waits for response; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src_address  input  32  byte address of first source word.
REQ-007 dst_address  input  32  byte address of first destination word.
REQ-008 length  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-009 busy  output  1  high while in RD or WR.
REQ-010 done  output  1  one-cycle pulse when a copy ends, whether success or error.
REQ-011 error  output  1  high if the last copy ended by timeout; cleared by the next accepted start.
REQ-012 read  output  1  bus read request, held until response.
REQ-013 write  output  1  bus write request, held until response.
REQ-014 address  output  32  bus address; 0 when read and write are both low.
REQ-015 write_data  output  32  bus write data; valid while write is high, 0 otherwise.
REQ-016 read_data  input  32  bus read data; valid in a cycle where read and response are both high.
REQ-017 response  input  1  responder acknowledge; completes the current phase in the same cycle it is high.

Function
REQ-018 The block shall be a bus initiator with states IDLE, RD, WR and FINISH.
REQ-019 IDLE, start=1, length!=0: latch src_address, dst_address and length, clear error, go to RD.
REQ-020 IDLE, start=1, length=0: go to FINISH with no bus activity and clear error.
REQ-021 RD: drive read=1 and address=current source address, both stable every cycle until response.
REQ-022 RD with response=1: capture read_data into a 32-bit buffer, add 4 to the source address, go to WR.
REQ-023 WR: drive write=1, address=current destination address and write_data=buffer, all stable until response.
REQ-024 WR with response=1: add 4 to the destination address and decrement the remaining count; go to FINISH if the count reaches 0, else go to RD.
REQ-025 Address increments shall wrap modulo 2^32, so 0xFFFFFFFC+4=0x00000000.
REQ-026 read and write shall never be high in the same cycle, and neither shall be high outside RD/WR.
REQ-027 Per-phase wait counter: cleared on entering RD or WR, incremented each cycle response=0.
REQ-028 If response stays low for TIMEOUT consecutive cycles of one phase, set error=1, go to FINISH and abandon the remaining words.
REQ-029 FINISH shall pulse done=1 for exactly one cycle, then go to IDLE.
REQ-030 start is ignored outside IDLE, including in the FINISH cycle.
REQ-031 With a zero-wait responder, a copy of L words accepted at edge 0 shall have RD at cycles 1,3,...,2L-1, WR at 2,4,...,2L, and done at cycle 2L+1.
REQ-032 response while read and write are both low shall be ignored.

Reset
REQ-033 On reset=1 at a clock edge the state shall become IDLE and every output shall be 0 in the next cycle: busy, done, error, read, write, address, write_data.
REQ-034 Reset mid-copy shall abandon the transfer with no further bus request and no done pulse.
REQ-035 Reset shall clear the buffer, latched addresses, remaining count and wait counter to 0.

Verification
REQ-036 Zero-wait responder, src=0x1000, dst=0x2000, length=3, source words A,B,C -> reads at 0x1000/0x1004/0x1008, writes A,B,C to 0x2000/0x2004/0x2008, done at cycle 7, error=0.
REQ-037 length=0 -> no read/write, done=1 at cycle 1, busy stays 0.
REQ-038 Responder delays response by 5 cycles on the first read -> read and address held stable for 6 cycles, then WR proceeds with the correct data.
REQ-039 TIMEOUT=8, responder never responds -> read high for cycles 1..8, FINISH at cycle 9 with done=1 and error=1, then IDLE; next start clears error.
REQ-040 Reset asserted during a WR cycle -> next cycle write=0, busy=0, address=0, and no done pulse follows.
REQ-041 src=0xFFFFFFFC, length=2, start re-pulsed while busy -> reads at 0xFFFFFFFC then 0x00000000; the extra start has no effect.
